multicycle_controller: RTL and testbench

Main control unit for the multi-cycle RV32 core. A state machine sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath multiplexer selects, the write strobes and the ALU control. It handshakes with the unified instruction/data memory. Immediate format selection stays in the separate immediate decoder; this block only sequences the datapath around it.

---
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32 core: sequences fetch/decode/execute/
// memory/write-back and drives datapath selects, write strobes and ALU control.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    state_e state_q, state_d;
    state_e decode_next;
    logic   illegal_q, illegal_d;
    logic   mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw, retire_raw;
    logic [2:0] funct_alu;

    // Opcode/funct legality check for the DECODE dispatch.
    always_comb begin
        decode_next = S_TRAP;
        case (op)
            OP_LOAD, OP_STORE: decode_next = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_R:              decode_next = (funct3 != 3'b011) ? S_EXECUTER : S_TRAP;
            OP_I:              decode_next = (funct3 != 3'b011) ? S_EXECUTEI : S_TRAP;
            OP_BRANCH:         decode_next = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
            OP_JAL:            decode_next = S_JAL;
            OP_LUI:            decode_next = S_LUI;
            default:           decode_next = S_TRAP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next;
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (state_q == S_EXECUTER && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_alu = ALU_SLL;
            3'b010:  funct_alu = ALU_SLT;
            3'b100:  funct_alu = ALU_XOR;
            3'b101:  funct_alu = ALU_SRL;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_control   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                retire_raw    = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_control  = ALU_SUB;
                pc_write_raw = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0;
                retire_raw   = 1'b1;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    // Strobes are held off combinationally while reset is asserted.
    assign mem_req   = mem_req_raw   & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign pc_write  = pc_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign retire    = retire_raw    & rst_n;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison against a
// trace built from instruction class, wait counts and the funct/branch rules.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_control(alu_control), .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal;
        logic [1:0] a, b, rs;
        logic [2:0] alu;
    } obs_t;

    typedef enum {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_LUI, K_ILL} kind_e;

    obs_t exp_q[$];
    bit   rdy_q[$];

    function automatic kind_e classify(input logic [6:0] o, input logic [2:0] f3);
        case (o)
            7'b0000011: return (f3 == 3'd2) ? K_LOAD  : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_STORE : K_ILL;
            7'b0110011: return (f3 == 3'd3) ? K_ILL : K_R;
            7'b0010011: return (f3 == 3'd3) ? K_ILL : K_I;
            7'b1100011: return (f3 <= 3'd1) ? K_BR  : K_ILL;
            7'b1101111: return K_JAL;
            7'b0110111: return K_LUI;
            default:    return K_ILL;
        endcase
    endfunction

    // Reference ALU op names: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 7.
    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input bit is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
            3'd1:    return 3'd6;
            3'd2:    return 3'd5;
            3'd4:    return 3'd4;
            3'd5:    return 3'd7;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic obs_t mk(input int st);
        obs_t o;
        o = '0;
        o.st = st[3:0];
        return o;
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st = state; o.mem_req = mem_req; o.mem_write = mem_write; o.adr_src = adr_src;
        o.ir_write = ir_write; o.pc_write = pc_write; o.reg_write = reg_write;
        o.retire = retire; o.illegal = illegal; o.a = alu_src_a; o.b = alu_src_b;
        o.rs = result_src; o.alu = alu_control;
        return o;
    endfunction

    task automatic push(input obs_t o, input bit r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endtask

    task automatic push_aluwb();
        obs_t c;
        c = mk(8); c.reg_write = 1'b1; c.retire = 1'b1;
        push(c, rnd());
    endtask

    task automatic build_trace(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input int fw, input int mw);
        obs_t  c;
        kind_e k;
        k = classify(o, f3);
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i <= fw; i++) begin
            c = mk(0); c.mem_req = 1'b1; c.b = 2'b10; c.rs = 2'b10;
            c.ir_write = (i == fw); c.pc_write = (i == fw);
            push(c, i == fw);
        end
        c = mk(1); c.a = 2'b01; c.b = 2'b01;
        push(c, rnd());
        case (k)
            K_LOAD, K_STORE: begin
                c = mk(2); c.a = 2'b10; c.b = 2'b01;
                push(c, rnd());
                for (int i = 0; i <= mw; i++) begin
                    c = mk(k == K_LOAD ? 3 : 5); c.mem_req = 1'b1; c.adr_src = 1'b1;
                    c.mem_write = (k == K_STORE); c.retire = (k == K_STORE) && (i == mw);
                    push(c, i == mw);
                end
                if (k == K_LOAD) begin
                    c = mk(4); c.rs = 2'b01; c.reg_write = 1'b1; c.retire = 1'b1;
                    push(c, rnd());
                end
            end
            K_R: begin
                c = mk(6); c.a = 2'b10; c.alu = alu_ref(f3, f7, 1'b1);
                push(c, rnd()); push_aluwb();
            end
            K_I: begin
                c = mk(7); c.a = 2'b10; c.b = 2'b01; c.alu = alu_ref(f3, f7, 1'b0);
                push(c, rnd()); push_aluwb();
            end
            K_BR: begin
                c = mk(9); c.a = 2'b10; c.alu = 3'd1; c.retire = 1'b1;
                c.pc_write = (f3 == 3'd0) ? z : ~z;
                push(c, rnd());
            end
            K_JAL: begin
                c = mk(10); c.a = 2'b01; c.b = 2'b10; c.pc_write = 1'b1;
                push(c, rnd()); push_aluwb();
            end
            K_LUI: begin
                c = mk(11); c.a = 2'b11; c.b = 2'b01;
                push(c, rnd()); push_aluwb();
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    c = mk(12); c.illegal = 1'b1;
                    push(c, rnd());
                end
            end
        endcase
    endtask

    // Enters and leaves aligned 1 time unit after a rising edge.
    task automatic run_trace(input string name);
        obs_t got;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = rdy_q[i];
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", name, i, got, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_write, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
                errors++;
                $display("FAIL %s strobes_in_reset got %b expected 000000", name,
                         {mem_req, mem_write, ir_write, pc_write, reg_write, retire});
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s after_reset got state %0d illegal %b expected 0 0", name, state, illegal);
        end
        rst_n = 1'b1;
    endtask

    task automatic do_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input int fw, input int mw);
        op = o; funct3 = f3; funct7_5 = f7; zero = z;
        build_trace(o, f3, f7, z, fw, mw);
        run_trace(name);
        if (classify(o, f3) == K_ILL) do_reset({name, "_clear"});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; op = 7'b0000011; funct3 = 3'd2; funct7_5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got state %0d illegal %b expected 0 0", state, illegal);
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL reset_reach_memread got %0d expected 3", state);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_write, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes got %b expected 000000",
                         {mem_req, mem_write, ir_write, pc_write, reg_write, retire});
            end
            @(posedge clk); #1;
            checks++;
            if (state !== 4'd0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_memread got state %0d illegal %b expected 0 0", state, illegal);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got state %0d mem_req %b expected 0 1", state, mem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops();
        do_instr("add", 7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("srl_f7", 7'b0110011, 3'd5, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_mem_wait();
        do_instr("lw_wait2", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 2);
        do_instr("sw_wait1", 7'b0100011, 3'd2, 1'b0, 1'b0, 1, 1);
        do_instr("sw", 7'b0100011, 3'd2, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        do_instr("beq_z1", 7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        do_instr("beq_z0", 7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("bne_z1", 7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
        do_instr("bne_z0", 7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_jal_lui();
        do_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("lui", 7'b0110111, 3'd5, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_trap();
        do_instr("trap_system", 7'b1110011, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("trap_r_f3", 7'b0110011, 3'd3, 1'b0, 1'b0, 0, 0);
        do_instr("trap_br_f3", 7'b1100011, 3'd4, 1'b0, 1'b0, 0, 0);
        do_instr("trap_lb", 7'b0000011, 3'd0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b1110011};
        for (int n = 0; n < 60; n++) begin
            do_instr("random", ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                     rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem_wait();
        test_branch();
        test_jal_lui();
        test_trap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
